// File: rtl/rs_encoder_ctrl.sv
// Stream-side sequencer for the RS(68,64) parallel parity encoder.
// Packs an incoming byte frame right-aligned into a 64-entry buffer,
// launches the encoder, captures its 4 parity bytes and streams out
// the systematic codeword (message bytes followed by parity).
module rs_encoder_ctrl #(
  parameter int K    = 64,
  parameter int NPAR = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               s_data,
  input  logic                     s_valid,
  input  logic                     s_last,
  output logic                     s_ready,
  output logic [K-1:0][7:0]        enc_msg,
  output logic                     enc_msg_valid,
  input  logic [NPAR-1:0][7:0]     enc_parity,
  input  logic                     enc_parity_valid,
  output logic [7:0]               m_data,
  output logic                     m_valid,
  output logic                     m_last,
  input  logic                     m_ready,
  output logic                     busy
);

  localparam logic [2:0] S_FILL     = 3'd0;
  localparam logic [2:0] S_LAUNCH   = 3'd1;
  localparam logic [2:0] S_WAIT     = 3'd2;
  localparam logic [2:0] S_SEND_MSG = 3'd3;
  localparam logic [2:0] S_SEND_PAR = 3'd4;

  logic [2:0]              state;
  logic [6:0]              count;
  logic [6:0]              n_len;
  logic [5:0]              rd;
  logic [1:0]              p;
  logic [K-1:0][7:0]       msg_buf;
  logic [NPAR-1:0][7:0]    par_q;
  logic                    accept;
  logic                    frame_end;

  assign s_ready       = (state == S_FILL);
  assign accept        = s_valid && s_ready;
  assign frame_end     = s_last || (count == 7'(K - 1));
  assign enc_msg       = msg_buf;
  assign enc_msg_valid = (state == S_LAUNCH);
  assign m_valid       = (state == S_SEND_MSG) || (state == S_SEND_PAR);
  assign m_last        = (state == S_SEND_PAR) && (p == 2'd3);
  assign busy          = !((state == S_FILL) && (count == 7'd0));

  // Output byte selection from registered state and read indices only
  always_comb begin
    m_data = 8'h00;
    case (state)
      S_SEND_MSG: m_data = msg_buf[rd];
      S_SEND_PAR: m_data = par_q[p];
      default:    m_data = 8'h00;
    endcase
  end

  // Sequencer: fill, launch, wait for parity, then send message and parity
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FILL;
      count   <= '0;
      n_len   <= '0;
      rd      <= '0;
      p       <= '0;
      msg_buf <= '0;
      par_q   <= '0;
    end else begin
      case (state)
        S_FILL: begin
          if (accept) begin
            // Shifting toward index 0 leaves a short frame right-aligned
            // with leading zeros, which is the shortened-code placement.
            msg_buf <= {s_data, msg_buf[K-1:1]};
            count   <= count + 7'd1;
            if (frame_end) begin
              n_len <= count + 7'd1;
              state <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: state <= S_WAIT;
        S_WAIT: begin
          if (enc_parity_valid) begin
            par_q <= enc_parity;
            rd    <= 6'(7'(K) - n_len);
            state <= S_SEND_MSG;
          end
        end
        S_SEND_MSG: begin
          if (m_ready) begin
            if (rd == 6'(K - 1)) begin
              p     <= '0;
              state <= S_SEND_PAR;
            end else begin
              rd <= rd + 6'd1;
            end
          end
        end
        S_SEND_PAR: begin
          if (m_ready) begin
            if (p == 2'd3) begin
              msg_buf <= '0;
              count   <= '0;
              state   <= S_FILL;
            end else begin
              p <= p + 2'd1;
            end
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

endmodule
